// File: rtl/stream_merger_pkg.sv
// Shared types and widths for the stream merger slice.
// Widths come from the shared ADDRESS_WIDTH / ID_WIDTH defines; the fallbacks only apply when they are absent.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

package stream_merger_pkg;
  localparam int unsigned ADDR_W      = `ADDRESS_WIDTH;
  localparam int unsigned ID_W        = `ID_WIDTH;
  localparam int unsigned FLUSH_CNT_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [ID_W-1:0]   id;
  } beat_t;

  typedef enum logic {
    CH_1 = 1'b0,
    CH_2 = 1'b1
  } chan_e;
endpackage

// File: rtl/stream_merger_if.sv
// Producer-side and downstream signals of the stream merger.
// flushed_count exists only when STREAM_MERGER_FLUSH_COUNT_EN is defined.
interface stream_merger_if;
  import stream_merger_pkg::*;

  logic [ADDR_W-1:0] in_address_1;
  logic [ADDR_W-1:0] in_address_2;
  logic [ID_W-1:0]   in_id_1;
  logic [ID_W-1:0]   in_id_2;
  logic              in_valid_1;
  logic              in_valid_2;
  logic              flush_1;
  logic              flush_2;
  logic [ID_W-1:0]   flush_id_1;
  logic [ID_W-1:0]   flush_id_2;
  logic              in_ready;
  logic              out_stall;
  logic [ADDR_W-1:0] out_address;
  logic [ID_W-1:0]   out_id;
  logic              out_valid;
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
  logic [FLUSH_CNT_W-1:0] flushed_count;
`endif

  modport master (
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
    input  flushed_count,
`endif
    output in_address_1, in_address_2, in_id_1, in_id_2, in_valid_1, in_valid_2,
    output flush_1, flush_2, flush_id_1, flush_id_2, in_ready,
    input  out_stall, out_address, out_id, out_valid
  );

  modport slave (
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
    output flushed_count,
`endif
    input  in_address_1, in_address_2, in_id_1, in_id_2, in_valid_1, in_valid_2,
    input  flush_1, flush_2, flush_id_1, flush_id_2, in_ready,
    output out_stall, out_address, out_id, out_valid
  );
endinterface

// File: rtl/stream_merger_fifo.sv
// Per-channel beat FIFO with push, pop and flush-truncate from the oldest matching ID.
module stream_fifo
  import stream_merger_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  input  logic             flush,
  input  logic [ID_W-1:0]  flush_id,
  output beat_t            head_c,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] discarded_c
);
  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] slot;
  logic [PTR_W-1:0] wr_slot;
  logic             match_found;
  logic [CNT_W-1:0] match_off;
  logic [CNT_W-1:0] keep;
  logic             wr_en;

  // Offset from head of the oldest valid entry carrying flush_id
  always_comb begin
    match_found = 1'b0;
    match_off   = '0;
    slot        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head_ptr + PTR_W'(i);
      if (!match_found && (CNT_W'(i) < count) && (mem[slot].id == flush_id)) begin
        match_found = 1'b1;
        match_off   = CNT_W'(i);
      end
    end
  end

  // keep = entries surviving truncation; a popped matching head is still delivered
  always_comb begin
    keep        = count;
    discarded_c = '0;
    if (flush) begin
      discarded_c = push ? CNT_W'(1) : '0;
      if (match_found) begin
        keep        = ((match_off == '0) && pop) ? CNT_W'(1) : match_off;
        discarded_c = discarded_c + (count - keep);
      end
    end
  end

  assign wr_en   = push && !flush;
  assign wr_slot = head_ptr + PTR_W'(count);
  assign head_c  = mem[head_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + PTR_W'(pop);
      count    <= keep - CNT_W'(pop) + CNT_W'(wr_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_slot] <= push_beat;
  end
endmodule

// File: rtl/stream_merger.sv
// Two-channel FIFO merger with round-robin arbitration and a global stall.
// STREAM_MERGER_FLUSH_COUNT_EN adds a saturating count of flushed entries.
module stream_merger
  import stream_merger_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  stream_merger_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  beat_t            push_beat_1, push_beat_2;
  beat_t            head_1_c, head_2_c, sel_beat_c;
  logic [CNT_W-1:0] count_1, count_2, disc_1_c, disc_2_c;
  logic             stall, valid_c, pop_c;
  logic             push_1, push_2, pop_1, pop_2;
  chan_e            rr_ptr, rr_nxt, sel_c;

  assign stall       = (count_1 == CNT_W'(DEPTH)) || (count_2 == CNT_W'(DEPTH));
  assign push_1      = bus.in_valid_1 && !stall;
  assign push_2      = bus.in_valid_2 && !stall;
  assign push_beat_1 = '{address: bus.in_address_1, id: bus.in_id_1};
  assign push_beat_2 = '{address: bus.in_address_2, id: bus.in_id_2};

  stream_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk(clk), .reset(reset), .push(push_1), .push_beat(push_beat_1), .pop(pop_1),
    .flush(bus.flush_1), .flush_id(bus.flush_id_1), .head_c(head_1_c), .count(count_1),
    .discarded_c(disc_1_c)
  );

  stream_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
    .clk(clk), .reset(reset), .push(push_2), .push_beat(push_beat_2), .pop(pop_2),
    .flush(bus.flush_2), .flush_id(bus.flush_id_2), .head_c(head_2_c), .count(count_2),
    .discarded_c(disc_2_c)
  );

  // A lone non-empty channel wins; with both pending rr_ptr decides
  always_comb begin
    sel_c = rr_ptr;
    if (count_1 == '0)      sel_c = CH_2;
    else if (count_2 == '0) sel_c = CH_1;
  end

  assign valid_c = (count_1 != '0) || (count_2 != '0);
  assign pop_c   = valid_c && bus.in_ready;
  assign pop_1   = pop_c && (sel_c == CH_1);
  assign pop_2   = pop_c && (sel_c == CH_2);

  always_comb begin
    rr_nxt = rr_ptr;
    if (pop_c) rr_nxt = (sel_c == CH_1) ? CH_2 : CH_1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= CH_1;
    else       rr_ptr <= rr_nxt;
  end

  assign sel_beat_c      = (sel_c == CH_1) ? head_1_c : head_2_c;
  assign bus.out_stall   = stall;
  assign bus.out_valid   = valid_c;
  assign bus.out_address = valid_c ? sel_beat_c.address : '0;
  assign bus.out_id      = valid_c ? sel_beat_c.id : '0;

`ifdef STREAM_MERGER_FLUSH_COUNT_EN
  localparam int unsigned SUM_W = FLUSH_CNT_W + 1;
  logic [SUM_W-1:0]       fc_sum_c;
  logic [FLUSH_CNT_W-1:0] flushed_count_q;

  assign fc_sum_c = SUM_W'(flushed_count_q) + SUM_W'(disc_1_c) + SUM_W'(disc_2_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    flushed_count_q <= '0;
    else if (fc_sum_c[FLUSH_CNT_W]) flushed_count_q <= '1;
    else                          flushed_count_q <= fc_sum_c[FLUSH_CNT_W-1:0];
  end

  assign bus.flushed_count = flushed_count_q;
`else
  logic unused_disc;
  assign unused_disc = ^{disc_1_c, disc_2_c};
`endif
endmodule

// File: tb/tb_stream_merger.sv
// Directed bench for stream_merger: queue-level reference model plus literal spot checks.
module tb_stream_merger;
  import stream_merger_pkg::*;

  localparam int unsigned DEPTH = 4;
  typedef beat_t beat_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_merger_if bus();
  stream_merger #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  beat_q_t     q1, q2, delivered;
  bit          rr_m;
  int unsigned fc_m;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return (q1.size() == DEPTH) || (q2.size() == DEPTH);
  endfunction

  function automatic bit m_valid();
    return (q1.size() != 0) || (q2.size() != 0);
  endfunction

  // 1 selects channel 2
  function automatic bit m_sel();
    if (q1.size() != 0 && q2.size() != 0) return rr_m;
    return q1.size() == 0;
  endfunction

  // Next contents of one channel queue: keep entries older than the first flush match
  function automatic beat_q_t chan_next(input beat_q_t q, input bit push, input beat_t b,
                                        input bit pop, input bit flush,
                                        input logic [ID_W-1:0] fid, output int unsigned disc);
    beat_q_t r;
    int keep;
    r    = q;
    keep = q.size();
    disc = 0;
    if (flush) begin
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].id == fid) keep = i;
      if (keep == 0 && pop) keep = 1;
      disc = (r.size() - keep) + (push ? 1 : 0);
      while (r.size() > keep) r.delete(r.size() - 1);
    end
    if (pop) r.delete(0);
    if (push && !flush) r.push_back(b);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q1.delete();
      q2.delete();
      rr_m = 1'b0;
      fc_m = 0;
    end else begin
      bit st, pv, sl;
      int unsigned d1, d2;
      beat_t b1, b2;
      st = m_stall();
      pv = m_valid() && bus.in_ready;
      sl = m_sel();
      b1 = '{address: bus.in_address_1, id: bus.in_id_1};
      b2 = '{address: bus.in_address_2, id: bus.in_id_2};
      q1 = chan_next(q1, bus.in_valid_1 && !st, b1, pv && !sl, bus.flush_1, bus.flush_id_1, d1);
      q2 = chan_next(q2, bus.in_valid_2 && !st, b2, pv && sl, bus.flush_2, bus.flush_id_2, d2);
      if (pv) rr_m = !sl;
      fc_m = (fc_m + d1 + d2 > 65535) ? 65535 : fc_m + d1 + d2;
    end
  end

  // Every cycle out of reset the DUT outputs must match the model
  always @(negedge clk) begin
    if (!reset) begin
      beat_t hb;
      hb = '0;
      if (m_valid()) hb = m_sel() ? q2[0] : q1[0];
      check("stall", bus.out_stall, m_stall());
      check("valid", bus.out_valid, m_valid());
      check("address", bus.out_address, hb.address);
      check("id", bus.out_id, hb.id);
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
      check("flushed_count", bus.flushed_count, fc_m);
`endif
      if (bus.out_valid && bus.in_ready)
        delivered.push_back('{address: bus.out_address, id: bus.out_id});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.in_valid_1 = 1'b0; bus.in_valid_2 = 1'b0;
    bus.flush_1 = 1'b0;    bus.flush_2 = 1'b0;
  endtask

  task automatic drive(input bit v1, input logic [ID_W-1:0] id1, input logic [ADDR_W-1:0] a1,
                       input bit v2, input logic [ID_W-1:0] id2, input logic [ADDR_W-1:0] a2);
    bus.in_valid_1 = v1; bus.in_id_1 = id1; bus.in_address_1 = a1;
    bus.in_valid_2 = v2; bus.in_id_2 = id2; bus.in_address_2 = a2;
  endtask

  task automatic do_reset();
    idle();
    bus.in_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    delivered.delete();
  endtask

  task automatic check_ids(input string name, input logic [ID_W-1:0] exp[$]);
    check({name, "_count"}, delivered.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < delivered.size()) ? delivered[i].id : '0, exp[i]);
  endtask

  initial begin
    int n;
    bit sb;
    logic [ID_W-1:0] exp_ids[$];
    drive(0, '0, '0, 0, '0, '0);
    bus.flush_id_1 = '0;
    bus.flush_id_2 = '0;
    do_reset();

    check("rst_valid", bus.out_valid, 0);
    check("rst_stall", bus.out_stall, 0);
    check("rst_id", bus.out_id, 0);
    check("rst_addr", bus.out_address, 0);

    // Single beat on ch1
    bus.in_ready = 1'b1;
    drive(1, 8'h11, 4, 0, '0, '0);
    tick();
    idle();
    check("t1_valid", bus.out_valid, 1);
    check("t1_id", bus.out_id, 8'h11);
    check("t1_addr", bus.out_address, 4);
    tick();
    check("t1_empty", bus.out_valid, 0);

    // Both channels streaming, ready held high
    do_reset();
    bus.in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, ID_W'(8'h11 + i), ADDR_W'(i), 1, ID_W'(8'h21 + i), ADDR_W'(16 + i));
      tick();
      check("t2_stall", bus.out_stall, 0);
    end
    idle();
    repeat (10) tick();
    exp_ids = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24, 8'h15, 8'h25};
    check_ids("t2_order", exp_ids);

    // Backpressure: stall after DEPTH pushes, producer holds its beat
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      sb = bus.out_stall;
      drive(1, ID_W'(8'h11 + n), ADDR_W'(n), 1, ID_W'(8'h21 + n), ADDR_W'(32 + n));
      tick();
      if (!sb) n++;
      check("t3_stall", bus.out_stall, cyc >= 3);
    end
    bus.in_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      sb = bus.out_stall;
      drive(1, ID_W'(8'h11 + n), ADDR_W'(n), 1, ID_W'(8'h21 + n), ADDR_W'(32 + n));
      tick();
      if (!sb) n++;
    end
    check("t3_pushed", n, 8);
    idle();
    repeat (12) tick();
    check("t3_delivered", delivered.size(), 16);

    // Flush on a full ch1 with a blocked push, then flush on ch2 with a live push
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, ID_W'(8'h12 + i), ADDR_W'(256 + i), 0, '0, '0);
      tick();
    end
    check("t4_full", bus.out_stall, 1);
    drive(1, 8'h16, 260, 0, '0, '0);
    bus.flush_1 = 1'b1; bus.flush_id_1 = 8'h14;
    tick();
    idle();
    check("t4_unstall", bus.out_stall, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, '0, 1, ID_W'(8'h21 + i), ADDR_W'(512 + i));
      tick();
    end
    drive(0, '0, '0, 1, 8'h24, 515);
    bus.flush_2 = 1'b1; bus.flush_id_2 = 8'h22;
    tick();
    idle();
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
    check("t4_fc", bus.flushed_count, 5);
`endif
    bus.in_ready = 1'b1;
    repeat (6) tick();
    exp_ids = '{8'h12, 8'h21, 8'h13};
    check_ids("t4_order", exp_ids);

    // Flush and pop hit the same ch1 head; ch2 flush misses
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, ID_W'(8'h14 + i), ADDR_W'(i), i < 2, ID_W'(8'h21 + i), ADDR_W'(64 + i));
      tick();
    end
    idle();
    bus.in_ready = 1'b1;
    bus.flush_1 = 1'b1; bus.flush_id_1 = 8'h14;
    bus.flush_2 = 1'b1; bus.flush_id_2 = 8'h2F;
    check("t5_head", bus.out_id, 8'h14);
    tick();
    idle();
    check("t5_next", bus.out_id, 8'h21);
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
    check("t5_fc", bus.flushed_count, 2);
`endif
    repeat (4) tick();
    exp_ids = '{8'h14, 8'h21, 8'h22};
    check_ids("t5_order", exp_ids);

    // Asynchronous reset while both FIFOs are full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, ID_W'(8'h11 + i), ADDR_W'(i), 1, ID_W'(8'h21 + i), ADDR_W'(8 + i));
      tick();
    end
    idle();
    bus.flush_1 = 1'b1; bus.flush_id_1 = 8'h14;
    tick();
    idle();
    check("t6_stall", bus.out_stall, 1);
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
    check("t6_fc_pre", bus.flushed_count, 1);
`endif
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_stall", bus.out_stall, 0);
    check("t6_rst_id", bus.out_id, 0);
    check("t6_rst_addr", bus.out_address, 0);
`ifdef STREAM_MERGER_FLUSH_COUNT_EN
    check("t6_rst_fc", bus.flushed_count, 0);
`endif
    tick();
    reset = 1'b0;
    bus.in_ready = 1'b1;
    tick();
    tick();
    check("t6_post_valid", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_merger.md
# stream_merger

Downstream stage of the dual-channel producer in the global-stall design. Two per-channel FIFOs accept address/ID beats under a single global stall. A round-robin arbiter merges them onto one output stream with a valid/ready handshake. Per-channel flush requests truncate the matching FIFO from the flushed ID onward.

## Interface
- DEPTH, 4, entries per channel FIFO; power of two, ≥2
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- in_address_1 / in_address_2  input  `ADDRESS_WIDTH  channel beat address
- in_id_1 / in_id_2  input  `ID_WIDTH  channel beat ID ([7:4] source tag, [3:0] sequence)
- in_valid_1 / in_valid_2  input  1  channel beat valid
- flush_1 / flush_2  input  1  single-cycle flush request for that channel
- flush_id_1 / flush_id_2  input  `ID_WIDTH  ID from which to flush
- out_stall  output  1  global stall, driven to both producer stall inputs
- out_address  output  `ADDRESS_WIDTH  merged beat address
- out_id  output  `ID_WIDTH  merged beat ID
- out_valid  output  1  merged beat valid
- in_ready  input  1  downstream accepts the merged beat

## Operation
- Push on channel k when in_valid_k && !out_stall at the clock edge; the beat is written to the FIFO_k tail. The producer's registers advance on the same edge.
- out_stall = (count_1 == DEPTH) || (count_2 == DEPTH). It is decoded only from registered counts and has no combinational input paths.
- Arbiter: candidates are the non-empty FIFO heads. With one candidate, that channel is selected. With both non-empty, the channel indicated by rr_ptr is selected.
- Pop the selected head when out_valid && in_ready. On pop, rr_ptr becomes the other channel. rr_ptr holds when no pop occurs.
- out_address, out_id and out_valid are combinational from the selected head. out_valid = count_1 != 0 || count_2 != 0.
- Flush on channel k:
  - Compare flush_id_k (full `ID_WIDTH`) against all valid FIFO_k entries.
  - At the oldest matching entry, set the tail to that entry's slot. That entry and all younger entries are discarded.
  - A push to channel k in the same cycle is discarded.
  - No match: the FIFO is unchanged, but a same-cycle push is still discarded.
  - The other channel is unaffected.
- Flush and pop on the same head entry in the same cycle: the pop wins. The entry is delivered and younger entries are discarded.
- Pointers are ptr-width $clog2(DEPTH) and wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide.
- Simultaneous push and pop on a full FIFO cannot occur, because stall blocks the push.

## Timing
- Reset values: out_stall 0, out_valid 0, out_address 0, out_id 0, both counts 0, rr_ptr = channel 1.
- Latency: a beat pushed at edge N is visible on the output from cycle N+1 if its FIFO was empty and it wins arbitration.
- The stall rises in the cycle after the push that fills a FIFO. It falls in the cycle after the pop that un-fills it.
- A flush takes effect at the edge where flush_k is sampled. Count and out_valid reflect the truncation from the next cycle.
- Reset mid-operation empties both FIFOs immediately. Queued beats are lost and no output is produced until new pushes.

## Configuration
- STREAM_MERGER_FLUSH_COUNT_EN defined:
  - Adds output flushed_count, 16 bits. It is reset to 0 and increases by the number of entries discarded per flush, counting discarded same-cycle pushes.
  - It saturates at 0xFFFF.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- `ADDRESS_WIDTH and `ID_WIDTH come from the shared defines.vh. No new global constants are added.
- Sub-module stream_fifo:
  - Parameterised on DEPTH.
  - Handles push, pop and flush-truncate.
  - Exposes head, count and a discarded-entry count.
  - Instantiated once per channel.
- The arbiter and stall decode live in stream_merger.

## Test plan
- Reset, then push 0x11/addr 4 on ch1 only, in_ready=1 → out_id 0x11 and out_address 4 on the next cycle, then out_valid 0.
- Both channels push every cycle with in_ready=1 → output alternates ch1/ch2 starting with ch1 (0x11, 0x21, 0x12, 0x22, …) and out_stall stays 0.
- in_ready=0, both channels pushing → out_stall rises after DEPTH pushes (cycle 5 with DEPTH=4). The producer holds, and no beat is lost or duplicated after in_ready returns to 1.
- ch1 queue holds 0x12, 0x13, 0x14, 0x15, and flush_1 with id 0x14 arrives alongside a push of 0x16 → count_1 becomes 2, and the output delivers 0x12, 0x13 only for ch1.
- flush_1 with id 0x14 when the head is 0x14 and it is popped in the same cycle → 0x14 is delivered and younger entries are dropped. flush_2 with non-matching id 0x2F → ch2 is unchanged.
- Assert reset with both FIFOs full and out_stall=1 → outputs go to 0 asynchronously. With STREAM_MERGER_FLUSH_COUNT_EN, flushed_count also returns to 0.
